// File: rtl/mem1port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem1port_arbiter
//  Description : Two-port (instruction / data) arbiter in front of a single-
//                port synchronous memory with a fixed 1-cycle read latency.
//                Grant is combinational. Read responses are routed back by a
//                one-deep tag pipeline. A saturating counter records the
//                number of cycles in which both ports request.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem1port_arbiter #(
    parameter int FIXED_PRIO = 0,
    parameter int CNTW       = 16
) (
    input  logic            clk,
    input  logic            reset,

    input  logic            i_req,
    input  logic [31:2]     i_addr,
    output logic            i_ack,
    output logic            i_rresp,
    output logic [31:0]     i_rdata,

    input  logic            d_req,
    input  logic            d_we,
    input  logic [31:2]     d_addr,
    input  logic [31:0]     d_wdata,
    input  logic [3:0]      d_wstrb,
    output logic            d_ack,
    output logic            d_rresp,
    output logic [31:0]     d_rdata,

    output logic            mem_ready,
    output logic            mem_we,
    output logic [31:2]     mem_addr,
    output logic [31:0]     mem_wdata,
    output logic [3:0]      mem_wstrb,
    input  logic            mem_rresp,
    input  logic [31:0]     mem_rdata,

    input  logic            cnt_clr,
    output logic [CNTW-1:0] conflict_cnt
);

    // Port identifiers used for the last-grant register and the response tag.
    localparam logic c_port_i = 1'b0;
    localparam logic c_port_d = 1'b1;

    logic            r_last_grant;  // port granted most recently
    logic            r_pending;     // a read was issued last cycle
    logic            r_tag;         // owner of that read
    logic [CNTW-1:0] r_cnt;

    logic            w_gnt_i;
    logic            w_gnt_d;
    logic            w_conflict;
    logic            w_read_issued;

    assign w_conflict = i_req & d_req;

    // Grant selection: D either always wins a conflict, or wins only when I
    // was the most recently served port. A lone requester always wins.
    generate
        if (FIXED_PRIO != 0) begin : g_fixed_prio
            assign w_gnt_d = d_req;
        end else begin : g_round_robin
            assign w_gnt_d = d_req & (~i_req | (r_last_grant == c_port_i));
        end
    endgenerate

    assign w_gnt_i = i_req & ~w_gnt_d;

    assign i_ack     = w_gnt_i;
    assign d_ack     = w_gnt_d;
    assign mem_ready = i_req | d_req;

    // A read goes out on any I grant, or on a D grant that is not a write.
    assign w_read_issued = w_gnt_i | (w_gnt_d & ~d_we);

    // Memory request mux; D-side write fields are only forwarded on a D
    // grant so they are don't-care whenever d_req is low.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = 4'b0000;
        if (w_gnt_i) begin
            mem_addr = i_addr;
        end else if (w_gnt_d) begin
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_wstrb = d_wstrb;
        end
    end

    // Remember who was served last; only meaningful for round-robin. Reset
    // value of D makes I win the first conflict.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_grant <= c_port_d;
        end else if (w_gnt_i) begin
            r_last_grant <= c_port_i;
        end else if (w_gnt_d) begin
            r_last_grant <= c_port_d;
        end
    end

    // One-deep response pipeline: the memory answers exactly one cycle after
    // a read, so a single pending/tag pair per cycle sustains back-to-back
    // reads. Reset drops any read in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= 1'b0;
            r_tag     <= c_port_i;
        end else begin
            r_pending <= w_read_issued;
            if (w_read_issued) begin
                r_tag <= w_gnt_d;
            end
        end
    end

    // Route the returning read data to its owner.
    assign i_rresp = mem_rresp & r_pending & (r_tag == c_port_i);
    assign d_rresp = mem_rresp & r_pending & (r_tag == c_port_d);
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

    // Saturating conflict counter; clear has priority over increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (cnt_clr) begin
            r_cnt <= '0;
        end else if (w_conflict && (r_cnt != {CNTW{1'b1}})) begin
            r_cnt <= r_cnt + CNTW'(1);
        end
    end

    assign conflict_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mem1port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem1port_arbiter
//  Description : Bench for mem1port_arbiter. Two instances run side by side:
//                index 0 is round-robin with a 16-bit counter, index 1 is
//                fixed D priority with a 4-bit counter. Each is compared
//                cycle by cycle against a behavioural model of the arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem1port_arbiter;

    logic        clk = 1'b0;
    logic        reset;

    logic        i_req     [2];
    logic [29:0] i_addr    [2];
    logic        d_req     [2];
    logic        d_we      [2];
    logic [29:0] d_addr    [2];
    logic [31:0] d_wdata   [2];
    logic [3:0]  d_wstrb   [2];
    logic        mem_rresp [2];
    logic [31:0] mem_rdata [2];
    logic        cnt_clr   [2];

    logic        i_ack     [2];
    logic        i_rresp   [2];
    logic [31:0] i_rdata   [2];
    logic        d_ack     [2];
    logic        d_rresp   [2];
    logic [31:0] d_rdata   [2];
    logic        mem_ready [2];
    logic        mem_we    [2];
    logic [29:0] mem_addr  [2];
    logic [31:0] mem_wdata [2];
    logic [3:0]  mem_wstrb [2];
    logic [15:0] cnt0;
    logic [3:0]  cnt1;

    int vectors = 0;
    int fails   = 0;

    // Model state: last served port (0=I,1=D), port expecting data next
    // cycle (-1 none), conflict count and its ceiling.
    int m_last [2];
    int m_exp  [2];
    int m_cnt  [2];
    int m_max  [2] = '{65535, 15};
    bit m_gi   [2];
    bit m_gd   [2];

    mem1port_arbiter #(.FIXED_PRIO(0), .CNTW(16)) u_rr (
        .clk(clk), .reset(reset),
        .i_req(i_req[0]), .i_addr(i_addr[0]), .i_ack(i_ack[0]),
        .i_rresp(i_rresp[0]), .i_rdata(i_rdata[0]),
        .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]),
        .d_wdata(d_wdata[0]), .d_wstrb(d_wstrb[0]), .d_ack(d_ack[0]),
        .d_rresp(d_rresp[0]), .d_rdata(d_rdata[0]),
        .mem_ready(mem_ready[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_wstrb(mem_wstrb[0]),
        .mem_rresp(mem_rresp[0]), .mem_rdata(mem_rdata[0]),
        .cnt_clr(cnt_clr[0]), .conflict_cnt(cnt0)
    );

    mem1port_arbiter #(.FIXED_PRIO(1), .CNTW(4)) u_fp (
        .clk(clk), .reset(reset),
        .i_req(i_req[1]), .i_addr(i_addr[1]), .i_ack(i_ack[1]),
        .i_rresp(i_rresp[1]), .i_rdata(i_rdata[1]),
        .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]),
        .d_wdata(d_wdata[1]), .d_wstrb(d_wstrb[1]), .d_ack(d_ack[1]),
        .d_rresp(d_rresp[1]), .d_rdata(d_rdata[1]),
        .mem_ready(mem_ready[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_wstrb(mem_wstrb[1]),
        .mem_rresp(mem_rresp[1]), .mem_rdata(mem_rdata[1]),
        .cnt_clr(cnt_clr[1]), .conflict_cnt(cnt1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int k);
        m_last[k] = 1;
        m_exp[k]  = -1;
        m_cnt[k]  = 0;
    endtask

    // Predict this cycle's outputs from the rules and compare.
    task automatic check_outputs(input int k);
        bit gd;
        bit gi;
        logic [63:0] cnt_obs;
        gd = d_req[k] && (!i_req[k] || k == 1 || m_last[k] == 0);
        gi = i_req[k] && !gd;
        m_gi[k] = gi;
        m_gd[k] = gd;
        chk($sformatf("i_ack[%0d]", k), i_ack[k], gi);
        chk($sformatf("d_ack[%0d]", k), d_ack[k], gd);
        chk($sformatf("mem_ready[%0d]", k), mem_ready[k], i_req[k] | d_req[k]);
        if (gi) begin
            chk($sformatf("i_mem_we[%0d]", k), mem_we[k], 0);
            chk($sformatf("i_mem_addr[%0d]", k), mem_addr[k], i_addr[k]);
            chk($sformatf("i_mem_wstrb[%0d]", k), mem_wstrb[k], 0);
        end
        if (gd) begin
            chk($sformatf("d_mem_we[%0d]", k), mem_we[k], d_we[k]);
            chk($sformatf("d_mem_addr[%0d]", k), mem_addr[k], d_addr[k]);
            chk($sformatf("d_mem_wdata[%0d]", k), mem_wdata[k], d_wdata[k]);
            chk($sformatf("d_mem_wstrb[%0d]", k), mem_wstrb[k], d_wstrb[k]);
        end
        chk($sformatf("i_rresp[%0d]", k), i_rresp[k], mem_rresp[k] && m_exp[k] == 0);
        chk($sformatf("d_rresp[%0d]", k), d_rresp[k], mem_rresp[k] && m_exp[k] == 1);
        if (mem_rresp[k] && m_exp[k] == 0)
            chk($sformatf("i_rdata[%0d]", k), i_rdata[k], mem_rdata[k]);
        if (mem_rresp[k] && m_exp[k] == 1)
            chk($sformatf("d_rdata[%0d]", k), d_rdata[k], mem_rdata[k]);
        cnt_obs = (k == 0) ? 64'(cnt0) : 64'(cnt1);
        chk($sformatf("conflict_cnt[%0d]", k), cnt_obs, m_cnt[k]);
    endtask

    task automatic model_update(input int k);
        if (reset) begin
            model_reset(k);
        end else begin
            if (m_gi[k]) begin
                m_last[k] = 0;
                m_exp[k]  = 0;
            end else if (m_gd[k]) begin
                m_last[k] = 1;
                m_exp[k]  = d_we[k] ? -1 : 1;
            end else begin
                m_exp[k] = -1;
            end
            if (cnt_clr[k])
                m_cnt[k] = 0;
            else if (i_req[k] && d_req[k] && m_cnt[k] < m_max[k])
                m_cnt[k] = m_cnt[k] + 1;
        end
    endtask

    // One clock: inputs were set at the falling edge; check, clock, advance.
    task automatic cycle();
        #1;
        for (int k = 0; k < 2; k++) check_outputs(k);
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_update(k);
        @(negedge clk);
    endtask

    // Requesters drop a request once it has been acknowledged.
    task automatic retire();
        for (int k = 0; k < 2; k++) begin
            if (m_gi[k]) i_req[k] = 1'b0;
            if (m_gd[k]) d_req[k] = 1'b0;
        end
    endtask

    task automatic drive_both(input logic ir, input logic [29:0] ia, input logic dr,
                              input logic dw, input logic [29:0] da,
                              input logic [31:0] wd, input logic [3:0] ws);
        for (int k = 0; k < 2; k++) begin
            i_req[k]   = ir;
            i_addr[k]  = ia;
            d_req[k]   = dr;
            d_we[k]    = dw;
            d_addr[k]  = da;
            d_wdata[k] = wd;
            d_wstrb[k] = ws;
        end
    endtask

    task automatic mem_both(input logic r, input logic [31:0] d);
        for (int k = 0; k < 2; k++) begin
            mem_rresp[k] = r;
            mem_rdata[k] = d;
        end
    endtask

    task automatic clr_both(input logic c);
        for (int k = 0; k < 2; k++) cnt_clr[k] = c;
    endtask

    task automatic assert_reset();
        reset = 1'b1;
        for (int k = 0; k < 2; k++) model_reset(k);
    endtask

    initial begin
        assert_reset();
        drive_both(0, 0, 0, 0, 0, 0, 0);
        mem_both(0, 0);
        clr_both(0);
        cycle();
        cycle();
        reset = 1'b0;

        // Both read in the first cycle after reset: I then D (round-robin).
        drive_both(1, 30'h40, 1, 0, 30'h44, 32'h0, 4'h0);
        cycle();
        retire();
        mem_both(1, 32'h1111_0001);
        cycle();
        retire();
        mem_both(1, 32'h2222_0002);
        cycle();
        mem_both(0, 0);
        chk("first_conflict_cnt_rr", 64'(cnt0), 1);
        chk("first_conflict_cnt_fp", 64'(cnt1), 1);

        // Lone I read at word 0x10 and its response.
        drive_both(1, 30'h10, 0, 0, 0, 0, 0);
        cycle();
        drive_both(0, 0, 0, 0, 0, 0, 0);
        mem_both(1, 32'hDEAD_BEEF);
        cycle();
        mem_both(0, 0);

        // D write with partial strobes; a stray response must not be routed.
        drive_both(0, 0, 1, 1, 30'h20, 32'hCAFE_F00D, 4'b0011);
        cycle();
        drive_both(0, 0, 0, 0, 0, 0, 0);
        mem_both(1, 32'h5555_AAAA);
        cycle();
        mem_both(0, 0);

        // Continuous conflict for 4 cycles after a fresh reset.
        assert_reset();
        cycle();
        reset = 1'b0;
        drive_both(1, 30'h100, 1, 0, 30'h200, 0, 0);
        for (int i = 0; i < 4; i++) begin
            mem_both(i > 0, 32'hA000_0000 + 32'(i));
            cycle();
        end
        drive_both(0, 0, 0, 0, 0, 0, 0);
        mem_both(1, 32'hA000_0004);
        cycle();
        mem_both(0, 0);
        chk("four_conflicts_cnt_rr", 64'(cnt0), 4);
        chk("four_conflicts_cnt_fp", 64'(cnt1), 4);

        // Three conflict cycles with D re-requesting, then D drops.
        drive_both(1, 30'h300, 1, 0, 30'h304, 0, 0);
        repeat (3) cycle();
        for (int k = 0; k < 2; k++) d_req[k] = 1'b0;
        cycle();
        drive_both(0, 0, 0, 0, 0, 0, 0);
        cycle();

        // Reset lands the cycle after an I read: the response is dropped.
        drive_both(1, 30'h80, 0, 0, 0, 0, 0);
        cycle();
        drive_both(0, 0, 0, 0, 0, 0, 0);
        #2;
        assert_reset();
        mem_both(1, 32'hBAD0_0001);
        cycle();
        cycle();
        reset = 1'b0;
        mem_both(1, 32'hBAD0_0002);
        cycle();
        mem_both(0, 0);
        chk("post_reset_cnt_rr", 64'(cnt0), 0);
        drive_both(1, 30'h90, 1, 0, 30'h94, 0, 0);
        cycle();
        retire();
        cycle();
        retire();
        cycle();

        // Saturation of the narrow counter, then clear beating increment.
        drive_both(1, 30'h5, 1, 0, 30'h6, 0, 0);
        repeat (20) cycle();
        chk("saturated_cnt_fp", 64'(cnt1), 15);
        clr_both(1);
        cycle();
        clr_both(0);
        chk("clear_cnt_rr", 64'(cnt0), 0);
        chk("clear_cnt_fp", 64'(cnt1), 0);
        drive_both(0, 0, 0, 0, 0, 0, 0);
        cycle();

        // Randomised traffic, requests held until acknowledged.
        for (int n = 0; n < 300; n++) begin
            for (int k = 0; k < 2; k++) begin
                if (!i_req[k] || m_gi[k]) begin
                    i_req[k]  = 1'($urandom_range(0, 1));
                    i_addr[k] = 30'($urandom);
                end
                if (!d_req[k] || m_gd[k]) begin
                    d_req[k]   = 1'($urandom_range(0, 1));
                    d_we[k]    = 1'($urandom_range(0, 1));
                    d_addr[k]  = 30'($urandom);
                    d_wdata[k] = $urandom;
                    d_wstrb[k] = 4'($urandom);
                end
                mem_rresp[k] = 1'($urandom_range(0, 1));
                mem_rdata[k] = $urandom;
                cnt_clr[k]   = ($urandom_range(0, 31) == 0);
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
`default_nettype wire
